multicycle_control_unit: RTL
============================

# multicycle_control_unit

- Parametrised multi-cycle successor of the single-cycle combinational control unit.
- A state machine sequences each instruction through fetch, decode, execute, memory and writeback.
- Handshakes with instruction and data memory; evaluates {Z,N,C,V} branch conditions on a registered flag snapshot.
- Drives per-register load enables for a configurable register count. Sits between instruction memory / status register and the datapath muxes, ALU, PC and data memory.

## Interface
Parameters:
- NUM_REGS, 2, datapath registers with load enables (2..4).
- TIMEOUT_CYCLES, 16, memory-wait limit (used only with CU_TIMEOUT_EN).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- run  in  1  start/continue execution from IDLE.
- opcode  in  7  instruction opcode.
- status_flags  in  4  {Z,N,C,V}.
- instr_valid  in  1  instruction memory output valid.
- mem_ready  in  1  data memory access complete.
- ir_load  out  1  capture instruction.
- L_PC  out  1  load PC.
- pc_sel  out  1  0 = PC+1, 1 = branch target.
- D_W  out  1  data memory write.
- S_D  out  2  data mux select: 00 ALU, 01 memory.
- L_R  out  NUM_REGS  one-hot register load.
- S_A  out  2  mux A select.
- S_B  out  2  mux B select.
- ALU_Sel  out  4  ALU operation.
- busy  out  1  instruction in flight.
- fault  out  1  sticky error.

## Operation
- Opcode is latched in DECODE.
  - class = op[6:5]: 00 ALU, 01 load, 10 store, 11 jump.
  - func = op[4:2].
  - dst = op[1:0].
- Flags are snapshotted in DECODE; later flag changes are ignored.
- States: IDLE, FETCH, DECODE, EXECUTE, MEM_WAIT, WRITEBACK, FAULT.
- IDLE: outputs 0. Go to FETCH when run=1.
- FETCH: hold until instr_valid=1. In that cycle ir_load=1, then go to DECODE.
- DECODE: outputs 0.
  - Go to FAULT if class≠11 and dst ≥ NUM_REGS, or class=11 and func=111.
  - Jump goes to WRITEBACK; all other classes go to EXECUTE.
- EXECUTE:
  - ALU: S_A=00, S_B=00, ALU_Sel={0,func}, then WRITEBACK.
  - Load/store: S_B=01, ALU_Sel=0000 (address add), then MEM_WAIT.
- MEM_WAIT: S_B=01 and ALU_Sel=0000 are held. Store also drives D_W=1. Go to WRITEBACK on the cycle mem_ready=1.
- WRITEBACK: L_PC=1.
  - ALU: L_R[dst]=1, S_D=00.
  - Load: L_R[dst]=1, S_D=01.
  - Store: no register load.
  - Jump: pc_sel=taken.
  - Next state is FETCH if run=1, else IDLE.
- Jump conditions by func: 000 always, 001 Z, 010 !Z, 011 N, 100 C, 101 V, 110 !N. A non-taken jump still pulses L_PC with pc_sel=0.
- FAULT: fault=1 and all other outputs 0. Exit only by reset.
- busy=1 in every state except IDLE and FAULT.
- Outputs are a pure function of state and latched fields. There is no combinational path from any input to any output except ir_load←instr_valid and D_W/WRITEBACK entry←mem_ready timing (state-based only).

## Timing
- Reset: all outputs 0, state IDLE, latched fields cleared.
  - Reset is honoured in any state, including mid-MEM_WAIT. D_W drops the next cycle.
- Minimum cycles, counting FETCH with instr_valid already high:
  - ALU: 4.
  - Load/store: 5, plus mem_ready wait.
  - Jump: 3.
- L_PC and L_R are single-cycle pulses per instruction. Exactly one L_R bit is high, and only in WRITEBACK.
- instr_valid is sampled only in FETCH. mem_ready is sampled only in MEM_WAIT.
- If run drops mid-instruction, the instruction completes and then the block enters IDLE.

## Configuration
- CU_TIMEOUT_EN defined:
  - An 8-bit wait counter clears on MEM_WAIT entry and counts each MEM_WAIT cycle with mem_ready=0.
  - When the count reaches TIMEOUT_CYCLES, go to FAULT (D_W drops).
  - mem_ready on the same cycle as the limit wins, and the state goes to WRITEBACK.
- Undefined: no counter; MEM_WAIT waits indefinitely.

## Test plan
- Reset with rst_n=0 for 2 cycles mid-store (D_W=1) -> next cycle all outputs 0, state IDLE.
- run=1, instr_valid=1, opcode 0x0D (ALU func 011, dst 1) -> ALU_Sel=0011 in cycle 3; L_R=01 is wrong, L_R=2'b10 with S_D=00 and L_PC=1 in cycle 4.
- Load opcode 0x20, mem_ready delayed 3 cycles -> S_B=01 held through MEM_WAIT; WRITEBACK gives L_R=01, S_D=01, L_PC=1.
- Jump opcode 0x64 (Z), two runs with flags 1000 then 0000 at DECODE -> pc_sel=1 then pc_sel=0; L_PC=1 in both.
- NUM_REGS=2, opcode 0x03 -> fault=1 after DECODE, remaining stuck until rst_n=0.
- CU_TIMEOUT_EN with TIMEOUT_CYCLES=4: store with mem_ready held low -> fault=1 after 4 wait cycles. Repeat with mem_ready on wait cycle 4 -> normal WRITEBACK.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit: sequences FETCH/DECODE/EXECUTE/MEM_WAIT/WRITEBACK and drives datapath controls.
// Optional memory-wait timeout enabled by defining CU_TIMEOUT_EN.
module multicycle_control_unit #(
  parameter int unsigned NUM_REGS       = 2,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic [6:0]          opcode,
  input  logic [3:0]          status_flags,
  input  logic                instr_valid,
  input  logic                mem_ready,
  output logic                ir_load,
  output logic                L_PC,
  output logic                pc_sel,
  output logic                D_W,
  output logic [1:0]          S_D,
  output logic [NUM_REGS-1:0] L_R,
  output logic [1:0]          S_A,
  output logic [1:0]          S_B,
  output logic [3:0]          ALU_Sel,
  output logic                busy,
  output logic                fault
);

  localparam int unsigned OP_W   = 7;
  localparam int unsigned FLAG_W = 4;
  localparam int unsigned CNT_W  = 8;

  localparam logic [1:0] CL_ALU   = 2'b00;
  localparam logic [1:0] CL_LOAD  = 2'b01;
  localparam logic [1:0] CL_STORE = 2'b10;
  localparam logic [1:0] CL_JUMP  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_EXECUTE, ST_MEM_WAIT, ST_WRITEBACK, ST_FAULT
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [OP_W-1:0]     r_op;
  logic [FLAG_W-1:0]   r_flags;
  logic                w_timeout;
  logic                w_dec_fault;
  logic                w_taken;
  logic [1:0]          w_class;
  logic [2:0]          w_func;
  logic [1:0]          w_dst;
  logic [NUM_REGS-1:0] w_lr;

  assign w_class = r_op[6:5];
  assign w_func  = r_op[4:2];
  assign w_dst   = r_op[1:0];
  assign w_lr    = NUM_REGS'(1) << w_dst;

  // Illegal destination or reserved jump condition, judged on the opcode presented in DECODE.
  assign w_dec_fault = ((opcode[6:5] != CL_JUMP) && (32'(opcode[1:0]) >= NUM_REGS)) ||
                       ((opcode[6:5] == CL_JUMP) && (opcode[4:2] == 3'b111));

  // Branch condition on the flag snapshot {Z,N,C,V}.
  always_comb begin
    w_taken = 1'b0;
    case (w_func)
      3'b000:  w_taken = 1'b1;
      3'b001:  w_taken = r_flags[3];
      3'b010:  w_taken = ~r_flags[3];
      3'b011:  w_taken = r_flags[2];
      3'b100:  w_taken = r_flags[1];
      3'b101:  w_taken = r_flags[0];
      3'b110:  w_taken = ~r_flags[2];
      default: w_taken = 1'b0;
    endcase
  end

`ifdef CU_TIMEOUT_EN
  logic [CNT_W-1:0] r_wait_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (r_state == ST_EXECUTE) begin
      r_wait_cnt <= '0;
    end else if ((r_state == ST_MEM_WAIT) && !mem_ready) begin
      r_wait_cnt <= r_wait_cnt + CNT_W'(1);
    end
  end

  assign w_timeout = (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_timeout        = 1'b0;
`endif

  // State register and DECODE-time capture of opcode and flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_op    <= '0;
      r_flags <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_DECODE) begin
        r_op    <= opcode;
        r_flags <= status_flags;
      end
    end
  end

  // Next-state and control decode.
  always_comb begin
    w_next_state = r_state;
    ir_load      = 1'b0;
    L_PC         = 1'b0;
    pc_sel       = 1'b0;
    D_W          = 1'b0;
    S_D          = 2'b00;
    L_R          = '0;
    S_A          = 2'b00;
    S_B          = 2'b00;
    ALU_Sel      = 4'b0000;
    busy         = 1'b0;
    fault        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (run) w_next_state = ST_FETCH;
      end
      ST_FETCH: begin
        busy = 1'b1;
        if (instr_valid) begin
          ir_load      = 1'b1;
          w_next_state = ST_DECODE;
        end
      end
      ST_DECODE: begin
        busy = 1'b1;
        if (w_dec_fault)                 w_next_state = ST_FAULT;
        else if (opcode[6:5] == CL_JUMP) w_next_state = ST_WRITEBACK;
        else                             w_next_state = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        busy = 1'b1;
        if (w_class == CL_ALU) begin
          S_A          = 2'b00;
          S_B          = 2'b00;
          ALU_Sel      = {1'b0, w_func};
          w_next_state = ST_WRITEBACK;
        end else begin
          S_B          = 2'b01;
          w_next_state = ST_MEM_WAIT;
        end
      end
      ST_MEM_WAIT: begin
        busy = 1'b1;
        S_B  = 2'b01;
        D_W  = (w_class == CL_STORE);
        if (mem_ready)      w_next_state = ST_WRITEBACK;
        else if (w_timeout) w_next_state = ST_FAULT;
      end
      ST_WRITEBACK: begin
        busy = 1'b1;
        L_PC = 1'b1;
        case (w_class)
          CL_ALU:  L_R = w_lr;
          CL_LOAD: begin
            L_R = w_lr;
            S_D = 2'b01;
          end
          CL_JUMP: pc_sel = w_taken;
          default: L_R = '0;
        endcase
        w_next_state = run ? ST_FETCH : ST_IDLE;
      end
      ST_FAULT: begin
        fault = 1'b1;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

endmodule
